// File: rtl/phone_tx_queue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : phone_tx_queue                                               |
// | Description : Byte FIFO between the phone state machine and uart_tx.       |
// |               Queued bytes are handed to the UART one at a time. Each      |
// |               byte gets a one-cycle start strobe. The queue then waits     |
// |               for the UART done pulse, or gives up after a bounded         |
// |               number of clocks. A fixed idle gap follows each byte.        |
// | Ports       : CLK50MHz, reset        - clock, synchronous active-high rst  |
// |               wr_en, wr_data, flush  - enqueue / discard-queue requests    |
// |               full, empty, count     - queue occupancy                     |
// |               drop                   - pulse: a write hit a full queue     |
// |               o_Tx_DV, o_Tx_Byte     - start strobe and byte to uart_tx    |
// |               i_Tx_Done              - done pulse from uart_tx             |
// |               busy, tx_timeout       - engine active / done never arrived  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module phone_tx_queue #(
    parameter int DEPTH        = 4,
    parameter int GAP_CYCLES   = 16,
    parameter int DONE_TIMEOUT = 8191
) (
    input  logic                    CLK50MHz,
    input  logic                    reset,
    input  logic                    wr_en,
    input  logic [7:0]              wr_data,
    input  logic                    flush,
    output logic                    full,
    output logic                    empty,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    drop,
    output logic                    o_Tx_DV,
    output logic [7:0]              o_Tx_Byte,
    input  logic                    i_Tx_Done,
    output logic                    busy,
    output logic                    tx_timeout
);

    localparam int C_AW = $clog2(DEPTH);
    localparam int C_WW = $clog2(DONE_TIMEOUT + 1);
    localparam int C_GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

    localparam logic [C_AW:0]   C_FULL_CNT  = (C_AW + 1)'(DEPTH);
    localparam logic [C_WW-1:0] C_WAIT_LAST = C_WW'(DONE_TIMEOUT - 1);
    localparam logic [C_GW-1:0] C_GAP_LOAD  = C_GW'(GAP_CYCLES);
    localparam logic [C_GW-1:0] C_GAP_ONE   = C_GW'(1);

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_LAUNCH    = 2'd1;
    localparam logic [1:0] S_WAIT_DONE = 2'd2;
    localparam logic [1:0] S_GAP       = 2'd3;

    logic [7:0]      r_mem [DEPTH];
    logic [C_AW-1:0] r_head;
    logic [C_AW-1:0] r_tail;
    logic [C_AW:0]   r_count;
    logic            r_drop;

    logic [1:0]      r_state;
    logic            r_tx_dv;
    logic [7:0]      r_tx_byte;
    logic            r_timeout;
    logic [C_WW-1:0] r_wait_cnt;
    logic [C_GW-1:0] r_gap_cnt;

    logic            w_full;
    logic            w_empty;
    logic            w_push;
    logic            w_pop;

    assign w_full  = (r_count == C_FULL_CNT);
    assign w_empty = (r_count == '0);

    // Fullness is judged on the registered count only, so a pop in the same
    // cycle does not make room for a write. Flush swallows any write with it.
    assign w_push = wr_en & ~w_full & ~flush;
    assign w_pop  = (r_state == S_LAUNCH) & ~flush;

    // Storage is not reset; only the pointers and count define validity.
    always_ff @(posedge CLK50MHz) begin
        if (w_push) begin
            r_mem[r_tail] <= wr_data;
        end
    end

    // Pointers are exactly C_AW bits wide, so they wrap modulo DEPTH.
    always_ff @(posedge CLK50MHz) begin
        if (reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_drop  <= 1'b0;
        end else begin
            r_drop <= wr_en & w_full & ~flush;
            if (flush) begin
                r_head  <= r_tail;
                r_count <= '0;
            end else begin
                if (w_push) begin
                    r_tail <= r_tail + 1'b1;
                end
                if (w_pop) begin
                    r_head <= r_head + 1'b1;
                end
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + 1'b1;
                    2'b01:   r_count <= r_count - 1'b1;
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    // The strobe and byte are registered on the IDLE->LAUNCH edge, so both are
    // visible during the LAUNCH cycle itself. The head is popped at the end
    // of that cycle. The byte register then holds until the next launch.
    always_ff @(posedge CLK50MHz) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_tx_dv    <= 1'b0;
            r_tx_byte  <= 8'h00;
            r_timeout  <= 1'b0;
            r_wait_cnt <= '0;
            r_gap_cnt  <= '0;
        end else begin
            r_tx_dv   <= 1'b0;
            r_timeout <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (!w_empty && !flush) begin
                        r_state   <= S_LAUNCH;
                        r_tx_dv   <= 1'b1;
                        r_tx_byte <= r_mem[r_head];
                    end
                end
                S_LAUNCH: begin
                    r_state    <= S_WAIT_DONE;
                    r_wait_cnt <= '0;
                end
                S_WAIT_DONE: begin
                    if (i_Tx_Done || (r_wait_cnt == C_WAIT_LAST)) begin
                        r_timeout <= ~i_Tx_Done;
                        if (GAP_CYCLES == 0) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_state   <= S_GAP;
                            r_gap_cnt <= C_GAP_LOAD;
                        end
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                    end
                end
                S_GAP: begin
                    // The counter holds the idle cycles still to spend,
                    // including the current one.
                    if (r_gap_cnt <= C_GAP_ONE) begin
                        r_state   <= S_IDLE;
                        r_gap_cnt <= '0;
                    end else begin
                        r_gap_cnt <= r_gap_cnt - 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign full       = w_full;
    assign empty      = w_empty;
    assign count      = r_count;
    assign drop       = r_drop;
    assign o_Tx_DV    = r_tx_dv;
    assign o_Tx_Byte  = r_tx_byte;
    assign busy       = (r_state != S_IDLE);
    assign tx_timeout = r_timeout;

endmodule
`default_nettype wire
